pc_fetch_unit: RTL and testbench
================================

Name: pc_fetch_unit

Overview:
- Sits on the consuming side of the next-PC selector: holds the architectural PC and loads the selected next PC on controller command.
- Fetches the instruction at PC over a request/acknowledge instruction-memory port.
- Returns PC+4 to the next-PC path and the instruction word to the IR/decoder.
- Flags misaligned jump/branch targets and instruction-memory timeouts.

Parameters:
- RESET_PC, 32'h0000_3000, PC value after reset
- TIMEOUT, 16, max cycles REQ waits for imem_ack_i before aborting (≥2)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- npc_i  input  32  next PC from the next-PC selector
- pc_write_i  input  1  controller strobe: load npc_i into PC
- fetch_req_i  input  1  controller strobe: fetch instruction at PC
- imem_req_o  output  1  instruction-memory read request
- imem_addr_o  output  32  instruction-memory byte address
- imem_ack_i  input  1  memory data valid, single-cycle
- imem_rdata_i  input  32  memory read data
- pc_o  output  32  current PC
- pc_plus4_o  output  32  pc_o + 4, combinational
- instr_o  output  32  last fetched instruction, held
- instr_valid_o  output  1  one-cycle pulse: instr_o updated
- busy_o  output  1  high in REQ or DONE
- misalign_err_o  output  1  sticky: rejected pc_write with npc_i[1:0] != 0
- fetch_err_o  output  1  sticky: fetch timed out

Behaviour:
- Reset (async, immediate, any state):
  - pc_o = RESET_PC; instr_o = 0.
  - imem_req_o, instr_valid_o, busy_o, misalign_err_o, fetch_err_o = 0.
  - State = IDLE; pending register cleared; timeout counter = 0.
  - Reset mid-fetch drops the request; a later ack is ignored because state is IDLE.
- pc_plus4_o = pc_o + 32'd4, modulo 2^32; 32'hFFFF_FFFC wraps to 0.
- PC update, IDLE only:
  - pc_write_i with npc_i[1:0] == 0: pc_o <= npc_i next edge.
  - pc_write_i with npc_i[1:0] != 0: pc_o unchanged; misalign_err_o <= 1, sticky until rst.
- pc_write_i while busy: npc_i captured into a one-entry pending register (last write wins).
  - Applied to pc_o, with the same alignment check, on the edge leaving DONE.
  - The fetch in flight always uses the old PC.
- FSM states: IDLE, REQ, DONE.
  - IDLE→REQ on fetch_req_i.
    - If pc_write_i (aligned) is high in the same cycle, the fetch uses the new PC: PC loads first, REQ addresses npc_i.
    - If that write is misaligned, the fetch uses the unchanged PC.
  - REQ: imem_req_o = 1, imem_addr_o = pc_o, held stable until ack; counter increments each cycle.
    - On imem_ack_i: instr_o <= imem_rdata_i; go to DONE.
    - If the counter reaches TIMEOUT-1 without ack: fetch_err_o <= 1; go to IDLE; instr_o unchanged; no valid pulse.
  - DONE: instr_valid_o = 1 for exactly this cycle; apply pending PC; go to IDLE.
- Latency: fetch_req_i in cycle N; req asserted N+1; ack in cycle N+1+k gives instr_valid_o in N+2+k. Zero-wait memory gives a 2-cycle request-to-valid.
- fetch_req_i outside IDLE is ignored, not queued.
- imem_addr_o = pc_o in all states; imem_req_o is low outside REQ.
- imem_ack_i outside REQ is ignored.
- Ack and timeout in the same cycle: ack wins.

Test Plan:
- Reset, then fetch_req with ack next cycle returning 32'h2408_0005 → pc_o=32'h3000, pc_plus4_o=32'h3004, imem_addr_o=32'h3000, instr_valid_o one pulse 2 cycles after req, instr_o=32'h2408_0005.
- pc_write npc_i=32'h0000_3040 in IDLE, then fetch with ack delayed 3 cycles → imem_addr_o=32'h3040 held stable 4 cycles, valid pulse on cycle 5, busy_o high throughout.
- pc_write npc_i=32'h0000_3042 → pc_o stays 32'h3000, misalign_err_o=1 and remains 1 after further good writes until rst.
- pc_write 32'h3100 during REQ, then ack → fetch address 32'h3000; pc_o=32'h3100 in the cycle after the valid pulse. Simultaneous fetch_req+pc_write 32'h3200 in IDLE → imem_addr_o=32'h3200.
- Never ack with TIMEOUT=16 → imem_req_o drops after 16 cycles, fetch_err_o=1, no instr_valid_o, instr_o unchanged. Late ack afterwards → no effect.
- Assert rst during REQ → all outputs to reset values asynchronously, pc_o=32'h3000. pc_write 32'hFFFF_FFFC → pc_plus4_o=0.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// Program counter holder and single-outstanding instruction fetcher.
// Loads the next PC on command, fetches over a req/ack port, and flags bad targets and timeouts.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] npc_i,
  input  logic        pc_write_i,
  input  logic        fetch_req_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  output logic [31:0] instr_o,
  output logic        instr_valid_o,
  output logic        busy_o,
  output logic        misalign_err_o,
  output logic        fetch_err_o
);

  localparam int unsigned CntW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

  state_e            state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic [31:0]       instr_q, instr_d;
  logic [31:0]       pend_pc_q, pend_pc_d;
  logic              pend_valid_q, pend_valid_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              misalign_q, misalign_d;
  logic              fetch_err_q, fetch_err_d;

  // Deferred write: a write in the final busy cycle wins over the held one.
  logic              apply_v;
  logic [31:0]       apply_pc;

  always_comb begin
    apply_v  = pc_write_i | pend_valid_q;
    apply_pc = pc_write_i ? npc_i : pend_pc_q;
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    pend_pc_d    = pend_pc_q;
    pend_valid_d = pend_valid_q;
    cnt_d        = cnt_q;
    misalign_d   = misalign_q;
    fetch_err_d  = fetch_err_q;

    unique case (state_q)
      StIdle: begin
        if (pc_write_i) begin
          if (npc_i[1:0] == 2'b00) pc_d = npc_i;
          else                     misalign_d = 1'b1;
        end
        if (fetch_req_i) begin
          state_d = StReq;
          cnt_d   = '0;
        end
      end
      StReq: begin
        if (pc_write_i) begin
          pend_valid_d = 1'b1;
          pend_pc_d    = npc_i;
        end
        if (imem_ack_i) begin
          instr_d = imem_rdata_i;
          state_d = StDone;
        end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
          // Aborted fetch still releases any write held while busy.
          fetch_err_d  = 1'b1;
          state_d      = StIdle;
          pend_valid_d = 1'b0;
          if (apply_v) begin
            if (apply_pc[1:0] == 2'b00) pc_d = apply_pc;
            else                        misalign_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        state_d      = StIdle;
        pend_valid_d = 1'b0;
        if (apply_v) begin
          if (apply_pc[1:0] == 2'b00) pc_d = apply_pc;
          else                        misalign_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      pc_q         <= RESET_PC;
      instr_q      <= '0;
      pend_pc_q    <= '0;
      pend_valid_q <= 1'b0;
      cnt_q        <= '0;
      misalign_q   <= 1'b0;
      fetch_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      pend_pc_q    <= pend_pc_d;
      pend_valid_q <= pend_valid_d;
      cnt_q        <= cnt_d;
      misalign_q   <= misalign_d;
      fetch_err_q  <= fetch_err_d;
    end
  end

  always_comb begin
    imem_req_o     = (state_q == StReq);
    imem_addr_o    = pc_q;
    pc_o           = pc_q;
    pc_plus4_o     = pc_q + 32'd4;
    instr_o        = instr_q;
    instr_valid_o  = (state_q == StDone);
    busy_o         = (state_q != StIdle);
    misalign_err_o = misalign_q;
    fetch_err_o    = fetch_err_q;
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: write table, directed fetch/timeout/reset sequences,
// and randomized fetch transactions scored against a transaction-level model.
module tb_pc_fetch_unit;

  localparam logic [31:0] RstPc   = 32'h0000_3000;
  localparam int unsigned Timeout = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] npc_i;
  logic        pc_write_i;
  logic        fetch_req_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_rdata_i;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;
  logic [31:0] instr_o;
  logic        instr_valid_o;
  logic        busy_o;
  logic        misalign_err_o;
  logic        fetch_err_o;

  pc_fetch_unit #(
    .RESET_PC(RstPc),
    .TIMEOUT (Timeout)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .npc_i         (npc_i),
    .pc_write_i    (pc_write_i),
    .fetch_req_i   (fetch_req_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_ack_i    (imem_ack_i),
    .imem_rdata_i  (imem_rdata_i),
    .pc_o          (pc_o),
    .pc_plus4_o    (pc_plus4_o),
    .instr_o       (instr_o),
    .instr_valid_o (instr_valid_o),
    .busy_o        (busy_o),
    .misalign_err_o(misalign_err_o),
    .fetch_err_o   (fetch_err_o)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Architectural model state
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic        m_mis;
  logic        m_ferr;

  typedef struct {
    logic [31:0] npc;
    logic [31:0] exp_pc;
    logic [31:0] exp_p4;
    logic        exp_mis;
  } wr_vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic model_write(input logic [31:0] v);
    if (v[1:0] == 2'b00) m_pc = v;
    else                 m_mis = 1'b1;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, " pc"}, pc_o, m_pc);
    chk({tag, " pc_plus4"}, pc_plus4_o, m_pc + 32'd4);
    chk({tag, " addr"}, imem_addr_o, m_pc);
    chk({tag, " instr"}, instr_o, m_instr);
    chk({tag, " req"}, {31'd0, imem_req_o}, 32'd0);
    chk({tag, " valid"}, {31'd0, instr_valid_o}, 32'd0);
    chk({tag, " busy"}, {31'd0, busy_o}, 32'd0);
    chk({tag, " misalign"}, {31'd0, misalign_err_o}, {31'd0, m_mis});
    chk({tag, " fetch_err"}, {31'd0, fetch_err_o}, {31'd0, m_ferr});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #12;
    rst = 1'b0;
    m_pc = RstPc; m_instr = '0; m_mis = 1'b0; m_ferr = 1'b0;
    cycle();
  endtask

  task automatic idle_write(input logic [31:0] v);
    pc_write_i = 1'b1;
    npc_i      = v;
    cycle();
    pc_write_i = 1'b0;
    model_write(v);
  endtask

  // One fetch transaction; ack after k wait cycles; optional same-cycle write with the request
  // and optional write at busy cycle wr_at (0..k are REQ cycles, k+1 is the valid cycle).
  task automatic run_fetch(input int k, input logic [31:0] data,
                           input logic with_sim, input logic [31:0] sim_val,
                           input logic with_wr, input int wr_at, input logic [31:0] wr_val);
    logic [31:0] exp_addr;
    fetch_req_i = 1'b1;
    if (with_sim) begin
      pc_write_i = 1'b1;
      npc_i      = sim_val;
      model_write(sim_val);
    end
    exp_addr = m_pc;
    cycle();
    pc_write_i = 1'b0;
    for (int i = 0; i <= k; i++) begin
      chk("req high", {31'd0, imem_req_o}, 32'd1);
      chk("req addr", imem_addr_o, exp_addr);
      chk("req busy", {31'd0, busy_o}, 32'd1);
      chk("req no valid", {31'd0, instr_valid_o}, 32'd0);
      fetch_req_i  = 1'($urandom_range(0, 1));
      pc_write_i   = with_wr && (wr_at == i);
      npc_i        = wr_val;
      imem_ack_i   = (i == k);
      imem_rdata_i = (i == k) ? data : $urandom;
      cycle();
    end
    imem_ack_i  = 1'b0;
    fetch_req_i = 1'b0;
    m_instr     = data;
    chk("done valid", {31'd0, instr_valid_o}, 32'd1);
    chk("done instr", instr_o, data);
    chk("done busy", {31'd0, busy_o}, 32'd1);
    chk("done req low", {31'd0, imem_req_o}, 32'd0);
    chk("done pc old", pc_o, exp_addr);
    pc_write_i = with_wr && (wr_at == k + 1);
    npc_i      = wr_val;
    cycle();
    pc_write_i = 1'b0;
    if (with_wr) model_write(wr_val);
    check_idle("after fetch");
  endtask

  wr_vec_t wr_tbl[6];

  initial begin
    wr_tbl[0] = '{npc: 32'h0000_3040, exp_pc: 32'h0000_3040, exp_p4: 32'h0000_3044, exp_mis: 1'b0};
    wr_tbl[1] = '{npc: 32'h0000_3042, exp_pc: 32'h0000_3040, exp_p4: 32'h0000_3044, exp_mis: 1'b1};
    wr_tbl[2] = '{npc: 32'h0000_3100, exp_pc: 32'h0000_3100, exp_p4: 32'h0000_3104, exp_mis: 1'b1};
    wr_tbl[3] = '{npc: 32'hFFFF_FFFC, exp_pc: 32'hFFFF_FFFC, exp_p4: 32'h0000_0000, exp_mis: 1'b1};
    wr_tbl[4] = '{npc: 32'h0000_3001, exp_pc: 32'hFFFF_FFFC, exp_p4: 32'h0000_0000, exp_mis: 1'b1};
    wr_tbl[5] = '{npc: 32'h0000_0000, exp_pc: 32'h0000_0000, exp_p4: 32'h0000_0004, exp_mis: 1'b1};

    rst = 1'b0; npc_i = '0; pc_write_i = 1'b0; fetch_req_i = 1'b0;
    imem_ack_i = 1'b0; imem_rdata_i = '0;
    #2;
    do_reset();
    chk("reset pc", pc_o, 32'h0000_3000);
    chk("reset pc_plus4", pc_plus4_o, 32'h0000_3004);
    check_idle("reset");

    // Zero-wait fetch from the reset PC
    run_fetch(0, 32'h2408_0005, 1'b0, '0, 1'b0, 0, '0);
    chk("first instr", instr_o, 32'h2408_0005);

    // Idle write table, misalign stays sticky
    for (int i = 0; i < 6; i++) begin
      idle_write(wr_tbl[i].npc);
      chk($sformatf("tbl%0d pc", i), pc_o, wr_tbl[i].exp_pc);
      chk($sformatf("tbl%0d pc_plus4", i), pc_plus4_o, wr_tbl[i].exp_p4);
      chk($sformatf("tbl%0d misalign", i), {31'd0, misalign_err_o}, {31'd0, wr_tbl[i].exp_mis});
    end

    // Fetch at 3040 with three wait cycles
    do_reset();
    idle_write(32'h0000_3040);
    run_fetch(3, 32'hA5A5_0001, 1'b0, '0, 1'b0, 0, '0);

    // Write during REQ is deferred; simultaneous fetch+write uses the new PC
    do_reset();
    run_fetch(1, 32'h1111_2222, 1'b0, '0, 1'b1, 0, 32'h0000_3100);
    chk("deferred pc", pc_o, 32'h0000_3100);
    run_fetch(0, 32'h3333_4444, 1'b1, 32'h0000_3200, 1'b0, 0, '0);

    // Timeout with no ack, then a late ack
    fetch_req_i = 1'b1;
    cycle();
    fetch_req_i = 1'b0;
    for (int i = 0; i < int'(Timeout); i++) begin
      chk("to req high", {31'd0, imem_req_o}, 32'd1);
      chk("to no valid", {31'd0, instr_valid_o}, 32'd0);
      cycle();
    end
    m_ferr = 1'b1;
    check_idle("timeout");
    imem_ack_i   = 1'b1;
    imem_rdata_i = 32'hDEAD_BEEF;
    cycle();
    imem_ack_i = 1'b0;
    check_idle("late ack");

    // Asynchronous reset mid-fetch
    idle_write(32'h0000_0003);
    fetch_req_i = 1'b1;
    cycle();
    fetch_req_i = 1'b0;
    chk("pre-rst req", {31'd0, imem_req_o}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    m_pc = RstPc; m_instr = '0; m_mis = 1'b0; m_ferr = 1'b0;
    check_idle("async rst");
    imem_ack_i   = 1'b1;
    imem_rdata_i = 32'h0BAD_0BAD;
    cycle();
    rst = 1'b0;
    cycle();
    imem_ack_i = 1'b0;
    check_idle("post rst ack");
    idle_write(32'hFFFF_FFFC);
    chk("wrap pc_plus4", pc_plus4_o, 32'h0000_0000);

    // Randomized transactions
    for (int n = 0; n < 60; n++) begin
      logic [31:0] v;
      v = $urandom;
      if ($urandom_range(0, 3) != 0) v[1:0] = 2'b00;
      if ($urandom_range(0, 2) == 0) begin
        idle_write(v);
        check_idle("rnd write");
      end else begin
        int k;
        logic [31:0] s;
        k = $urandom_range(0, 5);
        s = $urandom;
        if ($urandom_range(0, 3) != 0) s[1:0] = 2'b00;
        run_fetch(k, $urandom, 1'($urandom_range(0, 1)), s,
                  1'($urandom_range(0, 1)), $urandom_range(0, k + 1), v);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
